// File: rtl/dcache_controller_if.sv
// CPU / tag-data SRAM / line-memory signal bundle for the write-back data cache controller.
interface dcache_controller_if;
  logic         cpu_req_i;
  logic         cpu_we_i;
  logic [31:0]  cpu_addr_i;
  logic [31:0]  cpu_wdata_i;
  logic [31:0]  cpu_rdata_o;
  logic         cpu_stall_o;
  logic         sram_enable_o;
  logic         sram_write_o;
  logic [3:0]   sram_idx_o;
  logic [24:0]  sram_tag_o;
  logic [255:0] sram_data_o;
  logic         sram_hit_i;
  logic [24:0]  sram_tag_i;
  logic [255:0] sram_data_i;
  logic         mem_req_o;
  logic         mem_we_o;
  logic [31:0]  mem_addr_o;
  logic [255:0] mem_data_o;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;

  modport slave (
    input  cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    input  sram_hit_i, sram_tag_i, sram_data_i, mem_data_i, mem_ack_i,
    output cpu_rdata_o, cpu_stall_o,
    output sram_enable_o, sram_write_o, sram_idx_o, sram_tag_o, sram_data_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );

  modport master (
    output cpu_req_i, cpu_we_i, cpu_addr_i, cpu_wdata_i,
    output sram_hit_i, sram_tag_i, sram_data_i, mem_data_i, mem_ack_i,
    input  cpu_rdata_o, cpu_stall_o,
    input  sram_enable_o, sram_write_o, sram_idx_o, sram_tag_o, sram_data_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_data_o
  );
endinterface

// File: rtl/dcache_controller.sv
// Write-back, write-allocate data cache controller: hits complete in the lookup cycle with no stall;
// misses stall the CPU through optional victim write-back, line fetch and a one-cycle refill.
module dcache_controller (
  input  logic               clk_i,
  input  logic               rst_i,
  dcache_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, REFILL} state_t;

  state_t       state;
  logic [31:2]  addr_q;
  logic         we_q;
  logic [31:0]  wdata_q;
  logic [22:0]  vtag_q;
  logic [255:0] victim_q;
  logic [255:0] line_q;
  logic         mem_req_q;
  logic         mem_we_q;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state     <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      vtag_q    <= '0;
      victim_q  <= '0;
      line_q    <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cpu_req_i && !bus.sram_hit_i) begin
            addr_q    <= bus.cpu_addr_i[31:2];
            we_q      <= bus.cpu_we_i;
            wdata_q   <= bus.cpu_wdata_i;
            vtag_q    <= bus.sram_tag_i[22:0];
            victim_q  <= bus.sram_data_i;
            mem_req_q <= 1'b1;
            if (bus.sram_tag_i[24] && bus.sram_tag_i[23]) begin
              state    <= WRITEBACK;
              mem_we_q <= 1'b1;
            end else begin
              state    <= ALLOCATE;
              mem_we_q <= 1'b0;
            end
          end
        end
        WRITEBACK: begin
          if (bus.mem_ack_i) begin
            state    <= ALLOCATE;
            mem_we_q <= 1'b0;
          end
        end
        ALLOCATE: begin
          if (bus.mem_ack_i) begin
            line_q    <= bus.mem_data_i;
            mem_req_q <= 1'b0;
            state     <= REFILL;
          end
        end
        REFILL:  state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Hit path is combinational from the live CPU access; miss phases only use captured state.
  always_comb begin
    bus.cpu_rdata_o   = '0;
    bus.cpu_stall_o   = 1'b0;
    bus.sram_enable_o = 1'b0;
    bus.sram_write_o  = 1'b0;
    bus.sram_idx_o    = '0;
    bus.sram_tag_o    = '0;
    bus.sram_data_o   = '0;
    bus.mem_req_o     = 1'b0;
    bus.mem_we_o      = 1'b0;
    bus.mem_addr_o    = '0;
    bus.mem_data_o    = '0;
    if (rst_i) begin
      bus.mem_req_o = mem_req_q;
      bus.mem_we_o  = mem_req_q & mem_we_q;
      case (state)
        IDLE: begin
          if (bus.cpu_req_i) begin
            bus.sram_enable_o = 1'b1;
            bus.sram_idx_o    = bus.cpu_addr_i[8:5];
            bus.sram_tag_o    = {1'b1, bus.cpu_we_i, bus.cpu_addr_i[31:9]};
            if (!bus.sram_hit_i) begin
              bus.cpu_stall_o = 1'b1;
            end else if (bus.cpu_we_i) begin
              bus.sram_write_o = 1'b1;
              bus.sram_data_o  = bus.sram_data_i;
              bus.sram_data_o[{bus.cpu_addr_i[4:2], 5'b0} +: 32] = bus.cpu_wdata_i;
            end else begin
              bus.cpu_rdata_o = bus.sram_data_i[{bus.cpu_addr_i[4:2], 5'b0} +: 32];
            end
          end
        end
        WRITEBACK: begin
          bus.cpu_stall_o = 1'b1;
          bus.mem_addr_o  = {vtag_q, addr_q[8:5], 5'b0};
          bus.mem_data_o  = victim_q;
        end
        ALLOCATE: begin
          bus.cpu_stall_o = 1'b1;
          bus.mem_addr_o  = {addr_q[31:5], 5'b0};
        end
        REFILL: begin
          bus.cpu_stall_o   = 1'b1;
          bus.sram_enable_o = 1'b1;
          bus.sram_write_o  = 1'b1;
          bus.sram_idx_o    = addr_q[8:5];
          bus.sram_tag_o    = {1'b1, we_q, addr_q[31:9]};
          bus.sram_data_o   = line_q;
          if (we_q) bus.sram_data_o[{addr_q[4:2], 5'b0} +: 32] = wdata_q;
        end
        default: bus.cpu_stall_o = 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_controller.sv
// Scenario bench for dcache_controller: expected values queued at stimulus time, popped at sampling.
module tb_dcache_controller;
  logic clk;
  logic rst;
  dcache_controller_if bus();

  dcache_controller dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int n_vec;
  int n_err;
  logic [255:0] exp_q[$];
  logic [255:0] e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.cpu_req_i   = 1'b0;
    bus.cpu_we_i    = 1'b0;
    bus.cpu_addr_i  = '0;
    bus.cpu_wdata_i = '0;
    bus.sram_hit_i  = 1'b0;
    bus.sram_tag_i  = '0;
    bus.sram_data_i = '0;
    bus.mem_data_i  = '0;
    bus.mem_ack_i   = 1'b0;
  endtask

  task automatic rand_line(output logic [255:0] l);
    for (int i = 0; i < 8; i++) l[32*i +: 32] = $urandom;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    bus.cpu_req_i  = 1'b1;
    bus.cpu_addr_i = 32'h0000_0044;
    tick(); tick();
    exp_q.push_back(256'(0)); exp_q.push_back(256'(0)); exp_q.push_back(256'(0));
    exp_q.push_back(256'(0)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.sram_enable_o !== e[0]) begin n_err++; $display("FAIL rst_enable got %0h want %0h", bus.sram_enable_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL rst_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL rst_mem_req got %0h want %0h", bus.mem_req_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL rst_write got %0h want %0h", bus.sram_write_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_rdata_o !== e[31:0]) begin n_err++; $display("FAIL rst_rdata got %0h want %0h", bus.cpu_rdata_o, e[31:0]); end
    rst = 1'b1;
    bus.cpu_req_i = 1'b0;
    #1;
    exp_q.push_back(256'(0)); exp_q.push_back(256'(0)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.sram_enable_o !== e[0]) begin n_err++; $display("FAIL post_rst_enable got %0h want %0h", bus.sram_enable_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL post_rst_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL post_rst_mem_req got %0h want %0h", bus.mem_req_o, e[0]); end
  endtask

  task automatic test_read_hit();
    logic [255:0] l;
    tick();
    rand_line(l);
    l[127:96] = 32'hDEAD_BEEF;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_004C;
    bus.sram_hit_i = 1'b1; bus.sram_data_i = l;
    #1;
    exp_q.push_back(256'(2)); exp_q.push_back(256'(32'hDEAD_BEEF)); exp_q.push_back(256'(0));
    exp_q.push_back(256'(0)); exp_q.push_back(256'(1)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.sram_idx_o !== e[3:0]) begin n_err++; $display("FAIL rd_idx got %0h want %0h", bus.sram_idx_o, e[3:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_rdata_o !== e[31:0]) begin n_err++; $display("FAIL rd_data got %0h want %0h", bus.cpu_rdata_o, e[31:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL rd_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL rd_mem_req got %0h want %0h", bus.mem_req_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_enable_o !== e[0]) begin n_err++; $display("FAIL rd_enable got %0h want %0h", bus.sram_enable_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL rd_write got %0h want %0h", bus.sram_write_o, e[0]); end
    // Idle without a request: everything quiet, including read data.
    tick();
    bus.cpu_req_i = 1'b0;
    #1;
    exp_q.push_back(256'(0)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_rdata_o !== e[31:0]) begin n_err++; $display("FAIL idle_rdata got %0h want %0h", bus.cpu_rdata_o, e[31:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_enable_o !== e[0]) begin n_err++; $display("FAIL idle_enable got %0h want %0h", bus.sram_enable_o, e[0]); end
  endtask

  task automatic test_write_hit();
    logic [255:0] l;
    logic [255:0] x;
    tick();
    rand_line(l);
    x = l;
    x[63:32] = 32'h1234_5678;
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h0000_0024;
    bus.cpu_wdata_i = 32'h1234_5678; bus.sram_hit_i = 1'b1; bus.sram_data_i = l;
    #1;
    exp_q.push_back(256'(1)); exp_q.push_back(256'(1)); exp_q.push_back(256'(3));
    exp_q.push_back(x); exp_q.push_back(256'(0)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.sram_idx_o !== e[3:0]) begin n_err++; $display("FAIL wr_idx got %0h want %0h", bus.sram_idx_o, e[3:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL wr_write got %0h want %0h", bus.sram_write_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_tag_o[24:23] !== e[1:0]) begin n_err++; $display("FAIL wr_tag_vd got %0h want %0h", bus.sram_tag_o[24:23], e[1:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_data_o !== e) begin n_err++; $display("FAIL wr_line got %h want %h", bus.sram_data_o, e); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL wr_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_rdata_o !== e[31:0]) begin n_err++; $display("FAIL wr_rdata got %0h want %0h", bus.cpu_rdata_o, e[31:0]); end
  endtask

  task automatic test_clean_miss();
    logic [255:0] fill;
    logic [255:0] junk;
    rand_line(fill);
    rand_line(junk);
    tick();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h0000_0444;
    bus.sram_hit_i = 1'b0; bus.sram_tag_i = '0; bus.sram_data_i = junk;
    #1;
    exp_q.push_back(256'(1)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL cm_stall_lookup got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL cm_write_lookup got %0h want %0h", bus.sram_write_o, e[0]); end
    for (int i = 0; i < 10; i++) begin
      tick();
      exp_q.push_back(256'(1)); exp_q.push_back(256'(0)); exp_q.push_back(256'(32'h0000_0440)); exp_q.push_back(256'(1));
      e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL cm_mem_req[%0d] got %0h want %0h", i, bus.mem_req_o, e[0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.mem_we_o !== e[0]) begin n_err++; $display("FAIL cm_mem_we[%0d] got %0h want %0h", i, bus.mem_we_o, e[0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.mem_addr_o !== e[31:0]) begin n_err++; $display("FAIL cm_mem_addr[%0d] got %0h want %0h", i, bus.mem_addr_o, e[31:0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL cm_stall[%0d] got %0h want %0h", i, bus.cpu_stall_o, e[0]); end
    end
    bus.mem_ack_i = 1'b1; bus.mem_data_i = fill;
    tick();
    bus.mem_ack_i = 1'b0; bus.mem_data_i = junk;
    #1;
    exp_q.push_back(256'(1)); exp_q.push_back(256'(2)); exp_q.push_back(256'({2'b10, 23'd2}));
    exp_q.push_back(fill); exp_q.push_back(256'(1)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL cm_refill_write got %0h want %0h", bus.sram_write_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_idx_o !== e[3:0]) begin n_err++; $display("FAIL cm_refill_idx got %0h want %0h", bus.sram_idx_o, e[3:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_tag_o !== e[24:0]) begin n_err++; $display("FAIL cm_refill_tag got %0h want %0h", bus.sram_tag_o, e[24:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_data_o !== e) begin n_err++; $display("FAIL cm_refill_line got %h want %h", bus.sram_data_o, e); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL cm_refill_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL cm_refill_mem_req got %0h want %0h", bus.mem_req_o, e[0]); end
    tick();
    bus.sram_hit_i = 1'b1; bus.sram_data_i = fill;
    #1;
    exp_q.push_back(256'(fill[63:32])); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_rdata_o !== e[31:0]) begin n_err++; $display("FAIL cm_rehit_rdata got %0h want %0h", bus.cpu_rdata_o, e[31:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL cm_rehit_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
  endtask

  task automatic test_dirty_miss();
    logic [255:0] victim;
    logic [255:0] fill;
    logic [255:0] merged;
    logic [255:0] junk;
    rand_line(victim);
    rand_line(fill);
    rand_line(junk);
    merged = fill;
    merged[95:64] = 32'hCAFE_F00D;
    tick();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b1; bus.cpu_addr_i = 32'h0000_0848;
    bus.cpu_wdata_i = 32'hCAFE_F00D; bus.sram_hit_i = 1'b0;
    bus.sram_tag_i = {2'b11, 23'h000001}; bus.sram_data_i = victim;
    tick();
    bus.sram_tag_i = '0; bus.sram_data_i = junk;
    #1;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(256'(1)); exp_q.push_back(256'(1)); exp_q.push_back(256'(32'h0000_0240)); exp_q.push_back(victim);
      e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL dm_wb_req[%0d] got %0h want %0h", i, bus.mem_req_o, e[0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.mem_we_o !== e[0]) begin n_err++; $display("FAIL dm_wb_we[%0d] got %0h want %0h", i, bus.mem_we_o, e[0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.mem_addr_o !== e[31:0]) begin n_err++; $display("FAIL dm_wb_addr[%0d] got %0h want %0h", i, bus.mem_addr_o, e[31:0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.mem_data_o !== e) begin n_err++; $display("FAIL dm_wb_data[%0d] got %h want %h", i, bus.mem_data_o, e); end
      tick();
    end
    bus.mem_ack_i = 1'b1; bus.mem_data_i = junk;
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    exp_q.push_back(256'(1)); exp_q.push_back(256'(0)); exp_q.push_back(256'(32'h0000_0840)); exp_q.push_back(256'(1));
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL dm_al_req got %0h want %0h", bus.mem_req_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.mem_we_o !== e[0]) begin n_err++; $display("FAIL dm_al_we got %0h want %0h", bus.mem_we_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.mem_addr_o !== e[31:0]) begin n_err++; $display("FAIL dm_al_addr got %0h want %0h", bus.mem_addr_o, e[31:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL dm_al_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    bus.mem_ack_i = 1'b1; bus.mem_data_i = fill;
    tick();
    bus.mem_ack_i = 1'b0; bus.mem_data_i = junk;
    #1;
    exp_q.push_back(256'(1)); exp_q.push_back(256'({2'b11, 23'd4})); exp_q.push_back(merged);
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL dm_refill_write got %0h want %0h", bus.sram_write_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_tag_o !== e[24:0]) begin n_err++; $display("FAIL dm_refill_tag got %0h want %0h", bus.sram_tag_o, e[24:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_data_o !== e) begin n_err++; $display("FAIL dm_refill_line got %h want %h", bus.sram_data_o, e); end
    tick();
    bus.sram_hit_i = 1'b1; bus.sram_data_i = merged;
    #1;
    exp_q.push_back(256'(1)); exp_q.push_back(256'(0)); exp_q.push_back(merged);
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL dm_rehit_write got %0h want %0h", bus.sram_write_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL dm_rehit_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.sram_data_o !== e) begin n_err++; $display("FAIL dm_rehit_line got %h want %h", bus.sram_data_o, e); end
  endtask

  task automatic test_reset_mid();
    logic [255:0] l;
    rand_line(l);
    tick();
    bus.cpu_req_i = 1'b1; bus.cpu_we_i = 1'b0; bus.cpu_addr_i = 32'h1000_0060;
    bus.sram_hit_i = 1'b0; bus.sram_tag_i = '0;
    tick();
    exp_q.push_back(256'(1));
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL rm_alloc_req got %0h want %0h", bus.mem_req_o, e[0]); end
    rst = 1'b0;
    #1;
    exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL rm_during_req got %0h want %0h", bus.mem_req_o, e[0]); end
    tick();
    rst = 1'b1; bus.cpu_req_i = 1'b0; bus.mem_ack_i = 1'b1; bus.mem_data_i = l;
    #1;
    exp_q.push_back(256'(0)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL rm_after_req got %0h want %0h", bus.mem_req_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL rm_after_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    tick();
    bus.mem_ack_i = 1'b0;
    #1;
    exp_q.push_back(256'(0)); exp_q.push_back(256'(0)); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.sram_write_o !== e[0]) begin n_err++; $display("FAIL rm_late_ack_write got %0h want %0h", bus.sram_write_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL rm_late_ack_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.mem_req_o !== e[0]) begin n_err++; $display("FAIL rm_late_ack_req got %0h want %0h", bus.mem_req_o, e[0]); end
    tick();
    bus.cpu_req_i = 1'b1; bus.cpu_addr_i = 32'h1000_0060; bus.sram_hit_i = 1'b1; bus.sram_data_i = l;
    #1;
    exp_q.push_back(256'(l[31:0])); exp_q.push_back(256'(0));
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_rdata_o !== e[31:0]) begin n_err++; $display("FAIL rm_hit_rdata got %0h want %0h", bus.cpu_rdata_o, e[31:0]); end
    e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL rm_hit_stall got %0h want %0h", bus.cpu_stall_o, e[0]); end
  endtask

  task automatic test_back_to_back();
    logic [255:0] l;
    logic [255:0] x;
    logic [31:0]  a;
    logic [31:0]  w;
    logic [2:0]   wi;
    for (int n = 0; n < 8; n++) begin
      tick();
      rand_line(l);
      a  = $urandom;
      w  = $urandom;
      wi = a[4:2];
      bus.cpu_req_i = 1'b1; bus.cpu_we_i = n[0]; bus.cpu_addr_i = a; bus.cpu_wdata_i = w;
      bus.sram_hit_i = 1'b1; bus.sram_data_i = l;
      #1;
      x = l;
      for (int k = 0; k < 8; k++) if (k == int'(wi)) x[32*k +: 32] = w;
      exp_q.push_back(256'(a[8:5])); exp_q.push_back(256'(0));
      if (n[0]) begin
        exp_q.push_back(x); exp_q.push_back(256'(0));
      end else begin
        exp_q.push_back(256'(0)); exp_q.push_back(256'(l >> (32 * int'(wi))) & 256'hFFFF_FFFF);
      end
      e = exp_q.pop_front(); n_vec++; if (bus.sram_idx_o !== e[3:0]) begin n_err++; $display("FAIL b2b_idx[%0d] got %0h want %0h", n, bus.sram_idx_o, e[3:0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.cpu_stall_o !== e[0]) begin n_err++; $display("FAIL b2b_stall[%0d] got %0h want %0h", n, bus.cpu_stall_o, e[0]); end
      e = exp_q.pop_front(); n_vec++; if (bus.sram_data_o !== e) begin n_err++; $display("FAIL b2b_line[%0d] got %h want %h", n, bus.sram_data_o, e); end
      e = exp_q.pop_front(); n_vec++; if (bus.cpu_rdata_o !== e[31:0]) begin n_err++; $display("FAIL b2b_rdata[%0d] got %0h want %0h", n, bus.cpu_rdata_o, e[31:0]); end
    end
    tick();
    idle_inputs();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst   = 1'b0;
    idle_inputs();
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dcache_controller.md
DCACHE_CONTROLLER -- requirements
Module: dcache_controller

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-003 clk_i  input  1  clock; all state changes on the rising edge.
REQ-004 rst_i  input  1  synchronous active-low reset.
REQ-005 cpu_req_i  input  1  CPU access request; CPU holds req/we/addr/wdata stable while cpu_stall_o=1.
REQ-006 cpu_we_i  input  1  1=store, 0=load.
REQ-007 cpu_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-008 cpu_wdata_i  input  32  store word.
REQ-009 cpu_rdata_o  output  32  load word.
REQ-010 cpu_stall_o  output  1  CPU must hold its access.
REQ-011 sram_enable_o  output  1  SRAM access strobe.
REQ-012 sram_write_o  output  1  SRAM line write.
REQ-013 sram_idx_o  output  4  set index.
REQ-014 sram_tag_o  output  25  {valid, dirty, tag[22:0]}.
REQ-015 sram_data_o  output  256  line to write.
REQ-016 sram_hit_i  input  1  lookup hit, combinational from idx/tag.
REQ-017 sram_tag_i  input  25  on miss: LRU victim {valid, dirty, tag}.
REQ-018 sram_data_i  input  256  hit line, or victim line on miss.
REQ-019 mem_req_o  output  1  memory request, held until ack.
REQ-020 mem_we_o  output  1  1=line write-back, 0=line fetch.
REQ-021 mem_addr_o  output  32  line-aligned address, bits [4:0]=0.
REQ-022 mem_data_o  output  256  write-back line.
REQ-023 mem_data_i  input  256  fetched line, valid with mem_ack_i.
REQ-024 mem_ack_i  input  1  one-cycle completion pulse, arbitrary latency.

Function
REQ-025 Address split SHALL be: tag=addr[31:9], index=addr[8:5], word=addr[4:2]; word w SHALL occupy line bits [32w+31:32w].
REQ-026 The FSM SHALL have states IDLE, WRITEBACK, ALLOCATE, REFILL.
REQ-027 IDLE, cpu_req_i=0: all sram_*/mem_* outputs 0, cpu_stall_o=0, no state change.
REQ-028 IDLE, cpu_req_i=1: sram_enable_o=1, sram_idx_o=index, sram_tag_o={1,cpu_we_i,tag}.
REQ-029 IDLE read hit: cpu_rdata_o=selected word of sram_data_i in the same cycle, cpu_stall_o=0, zero added latency.
REQ-030 IDLE write hit: same cycle sram_write_o=1, sram_tag_o={1,1,tag}, sram_data_o=sram_data_i with selected word replaced by cpu_wdata_i; cpu_stall_o=0.
REQ-031 IDLE miss: cpu_stall_o=1 combinationally; register addr, we, wdata, sram_tag_i, sram_data_i; next state WRITEBACK if victim valid&dirty, else ALLOCATE.
REQ-032 WRITEBACK: mem_req_o=1, mem_we_o=1, mem_addr_o={victim tag,index,5'b0}, mem_data_o=victim line, all held stable until mem_ack_i; on ack go to ALLOCATE.
REQ-033 ALLOCATE: mem_req_o=1, mem_we_o=0, mem_addr_o={tag,index,5'b0}; on ack register mem_data_i and go to REFILL.
REQ-034 mem_req_o MAY stay high from WRITEBACK into ALLOCATE; the change of mem_we_o/mem_addr_o marks the new transaction.
REQ-035 REFILL (one cycle): sram_enable_o=1, sram_write_o=1, sram_tag_o={1,we,tag}, sram_data_o=fetched line with the store word merged if we=1; then go to IDLE.
REQ-036 After REFILL, IDLE SHALL re-look up the held access; it hits and completes per REQ-029/REQ-030.
REQ-037 cpu_stall_o SHALL be 1 in WRITEBACK, ALLOCATE and REFILL.
REQ-038 mem_ack_i outside WRITEBACK/ALLOCATE SHALL be ignored.
REQ-039 cpu_rdata_o SHALL be 0 except during an IDLE read hit.

Reset
REQ-040 rst_i=0 at a clock edge SHALL force IDLE and clear all captured registers, including mid-transaction; the pending memory transaction is abandoned.
REQ-041 While rst_i=0 and in the first cycle after reset: mem_req_o=0, sram_enable_o=0, sram_write_o=0, cpu_stall_o=0, cpu_rdata_o=0.

Verification
REQ-042 Read hit, addr 0x0000004C, sram_hit_i=1, word3 of sram_data_i=0xDEADBEEF -> sram_idx_o=2, cpu_rdata_o=0xDEADBEEF same cycle, stall 0, mem_req_o 0.
REQ-043 Write hit, addr 0x00000024, wdata 0x12345678 -> sram_idx_o=1, sram_write_o=1, sram_tag_o[24:23]=2'b11, sram_data_o[63:32]=0x12345678, other bits equal sram_data_i.
REQ-044 Clean read miss, addr 0x00000444, sram_tag_i=0, ack after 10 cycles -> ALLOCATE, mem_we_o=0, mem_addr_o=0x00000440; REFILL writes tag {1,0,tag}; next IDLE hit releases stall.
REQ-045 Dirty miss, index 2, sram_tag_i={1,1,23'h000001} -> WRITEBACK, mem_we_o=1, mem_addr_o=0x00000240, mem_data_o=victim line; after ack -> ALLOCATE read.
REQ-046 rst_i=0 for one cycle during ALLOCATE -> next cycle IDLE, mem_req_o=0, cpu_stall_o=0; a late mem_ack_i is ignored.
